// File: rtl/motion_integrator_pkg.sv
// rtl/motion_integrator_pkg.sv - shared types and constants for the sprite motion integrator
package motion_integrator_pkg;
  localparam int SPRITES    = 9;
  localparam int DIMENSIONS = 2;
  localparam int WIDTH      = 32;
  localparam int X_MAX      = 578;
  localparam int Y_MAX      = 418;
  localparam int AXIS_X     = 1;
  localparam int AXIS_Y     = 0;
  localparam int IDX_W      = $clog2(SPRITES);

  typedef logic [WIDTH-1:0] coord_t;
  typedef coord_t [DIMENSIONS-1:0] vec_t;
  typedef vec_t [SPRITES-1:0] sprite_arr_t;

  typedef enum logic [1:0] {IDLE, STEP, FIN} integ_state_t;
endpackage

// File: rtl/motion_integrator_if.sv
// rtl/motion_integrator_if.sv - control and sprite-state bundle between the integrator and its neighbours
interface motion_integrator_if;
  import motion_integrator_pkg::*;

  logic        frame_tick;
  logic        load;
  sprite_arr_t init_locs;
  sprite_arr_t init_velos;
  sprite_arr_t new_velos;
  sprite_arr_t locations;
  sprite_arr_t velos;
  logic        busy;
  logic        done;
  logic        overrun;

  modport master (
    output frame_tick, load, init_locs, init_velos, new_velos,
    input  locations, velos, busy, done, overrun
  );

  modport slave (
    input  frame_tick, load, init_locs, init_velos, new_velos,
    output locations, velos, busy, done, overrun
  );
endinterface

// File: rtl/motion_integrator_axis_step.sv
// rtl/motion_integrator_axis_step.sv - one-axis position advance with wall reflection
module axis_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_loc,
  input  logic [WIDTH-1:0] i_vel,
  input  logic [WIDTH-1:0] i_limit,
  output logic [WIDTH-1:0] o_next_loc,
  output logic [WIDTH-1:0] o_next_vel
);
  // One extra bit keeps the unsigned location plus signed velocity free of overflow.
  logic signed [WIDTH:0] w_sum;
  logic signed [WIDTH:0] w_limit;

  assign w_sum   = $signed({1'b0, i_loc}) + $signed({i_vel[WIDTH-1], i_vel});
  assign w_limit = $signed({1'b0, i_limit});

  // Clamp to the wall and reverse velocity when the step leaves [0, limit].
  always_comb begin
    o_next_loc = w_sum[WIDTH-1:0];
    o_next_vel = i_vel;
    if (w_sum < 0) begin
      o_next_loc = '0;
      o_next_vel = -i_vel;
    end else if (w_sum > w_limit) begin
      o_next_loc = i_limit;
      o_next_vel = -i_vel;
    end
  end
endmodule

// File: rtl/motion_integrator.sv
// rtl/motion_integrator.sv - per-frame sprite position integrator, one sprite per cycle
module motion_integrator
  import motion_integrator_pkg::*;
(
  input logic                clk,
  input logic                rst,
  motion_integrator_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPRITES - 1);
  localparam coord_t           X_LIMIT  = coord_t'(X_MAX);
  localparam coord_t           Y_LIMIT  = coord_t'(Y_MAX);

  integ_state_t     r_state;
  integ_state_t     w_next_state;
  logic [IDX_W-1:0] r_idx;
  sprite_arr_t      r_snap;
  sprite_arr_t      r_locs;
  sprite_arr_t      r_velos;
  logic             r_overrun;

  vec_t             w_cur_loc;
  vec_t             w_cur_vel;
  coord_t           w_x_loc;
  coord_t           w_x_vel;
  coord_t           w_y_loc;
  coord_t           w_y_vel;

  // The sprite under update reads its live location and the frozen snapshot velocity.
  assign w_cur_loc = r_locs[r_idx];
  assign w_cur_vel = r_snap[r_idx];

  axis_step #(.WIDTH(WIDTH)) u_step_x (
    .i_loc      (w_cur_loc[AXIS_X]),
    .i_vel      (w_cur_vel[AXIS_X]),
    .i_limit    (X_LIMIT),
    .o_next_loc (w_x_loc),
    .o_next_vel (w_x_vel)
  );

  axis_step #(.WIDTH(WIDTH)) u_step_y (
    .i_loc      (w_cur_loc[AXIS_Y]),
    .i_vel      (w_cur_vel[AXIS_Y]),
    .i_limit    (Y_LIMIT),
    .o_next_loc (w_y_loc),
    .o_next_vel (w_y_vel)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next state: load always returns to IDLE; otherwise walk IDLE -> STEP x SPRITES -> FIN.
  always_comb begin
    w_next_state = r_state;
    if (bus.load) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.frame_tick) w_next_state = STEP;
        STEP:    if (r_idx == LAST_IDX) w_next_state = FIN;
        FIN:     w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Datapath: snapshot, per-sprite update, load of initial state, and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_snap    <= '0;
      r_locs    <= '0;
      r_velos   <= '0;
      r_overrun <= 1'b0;
    end else if (bus.load) begin
      r_idx     <= '0;
      r_locs    <= bus.init_locs;
      r_velos   <= bus.init_velos;
      r_overrun <= 1'b0;
    end else begin
      if (bus.frame_tick && r_state != IDLE) r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (bus.frame_tick) begin
            r_snap <= bus.new_velos;
            r_idx  <= '0;
          end
        end
        STEP: begin
          r_locs[r_idx][AXIS_X]  <= w_x_loc;
          r_locs[r_idx][AXIS_Y]  <= w_y_loc;
          r_velos[r_idx][AXIS_X] <= w_x_vel;
          r_velos[r_idx][AXIS_Y] <= w_y_vel;
          r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and registered sprite data.
  always_comb begin
    bus.busy      = (r_state != IDLE);
    bus.done      = (r_state == FIN);
    bus.overrun   = r_overrun;
    bus.locations = r_locs;
    bus.velos     = r_velos;
  end
endmodule

// File: tb/tb_motion_integrator.sv
// tb/tb_motion_integrator.sv - self-checking bench for motion_integrator
module tb_motion_integrator;
  import motion_integrator_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  motion_integrator_if mi_if();

  motion_integrator u_dut (
    .clk (clk),
    .rst (rst),
    .bus (mi_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int sprite;
    int lx, ly, vx, vy;
    int elx, ely, evx, evy;
  } vec_rec_t;

  vec_rec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_arr(input string name, input sprite_arr_t act, input sprite_arr_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkvec(input int x, input int y);
    vec_t r;
    r[AXIS_X] = coord_t'(x);
    r[AXIS_Y] = coord_t'(y);
    return r;
  endfunction

  task automatic load_state(input sprite_arr_t l, input sprite_arr_t v);
    mi_if.init_locs  = l;
    mi_if.init_velos = v;
    mi_if.load       = 1'b1;
    tick();
    mi_if.load       = 1'b0;
  endtask

  // Pulses frame_tick, returns cycles until done is seen (50 means it never came).
  task automatic run_frame(output int cycles);
    mi_if.frame_tick = 1'b1;
    tick();
    mi_if.frame_tick = 1'b0;
    cycles = 1;
    while (!mi_if.done && cycles < 50) begin
      tick();
      cycles++;
    end
    tick();
  endtask

  initial begin
    sprite_arr_t l, v, el, ev, l2, v2;
    int cyc, dcnt;

    mi_if.frame_tick = 1'b0;
    mi_if.load       = 1'b0;
    mi_if.init_locs  = '0;
    mi_if.init_velos = '0;
    mi_if.new_velos  = '0;

    tbl[0] = '{0, 100, 200,   3,  -5, 103, 195,   3,  -5};
    tbl[1] = '{2, 576,   2,   4,  -7, 578,   0,  -4,   7};
    tbl[2] = '{4, 578, 418,   0,   0, 578, 418,   0,   0};
    tbl[3] = '{8, 578, 418,   1,   1, 578, 418,  -1,  -1};
    tbl[4] = '{1,   0,   0,  -1,  -1,   0,   0,   1,   1};
    tbl[5] = '{3, 570, 410,   8,   8, 578, 418,   8,   8};
    tbl[6] = '{6,   5,   5,  -5,  -5,   0,   0,  -5,  -5};
    tbl[7] = '{7,  10, 300, -20, 200,   0, 418,  20, -200};

    tick();
    tick();
    chk_arr("reset_locations", mi_if.locations, '0);
    chk_arr("reset_velos", mi_if.velos, '0);
    chk("reset_busy", mi_if.busy, 0);
    chk("reset_done", mi_if.done, 0);
    chk("reset_overrun", mi_if.overrun, 0);
    rst = 1'b0;
    tick();

    // Single-sprite frames from the vector table.
    for (int i = 0; i < 8; i++) begin
      l = '0; v = '0;
      l[tbl[i].sprite] = mkvec(tbl[i].lx, tbl[i].ly);
      v[tbl[i].sprite] = mkvec(tbl[i].vx, tbl[i].vy);
      el = '0; ev = '0;
      el[tbl[i].sprite] = mkvec(tbl[i].elx, tbl[i].ely);
      ev[tbl[i].sprite] = mkvec(tbl[i].evx, tbl[i].evy);
      mi_if.new_velos = v;
      load_state(l, v);
      chk_arr($sformatf("vec%0d_load_locs", i), mi_if.locations, l);
      run_frame(cyc);
      chk($sformatf("vec%0d_latency", i), cyc, 10);
      chk_arr($sformatf("vec%0d_locs", i), mi_if.locations, el);
      chk_arr($sformatf("vec%0d_velos", i), mi_if.velos, ev);
    end

    // Outputs update one sprite per cycle; busy holds through STEP and FIN.
    l = '0; v = '0;
    l[0] = mkvec(100, 200); v[0] = mkvec(3, -5);
    l[1] = mkvec(10, 10);   v[1] = mkvec(1, 1);
    mi_if.new_velos = v;
    load_state(l, v);
    mi_if.frame_tick = 1'b1;
    tick();
    mi_if.frame_tick = 1'b0;
    chk("seq_busy_c1", mi_if.busy, 1);
    chk("seq_s0_untouched_c1", mi_if.locations[0][AXIS_X], 100);
    tick();
    chk("seq_s0_x_c2", mi_if.locations[0][AXIS_X], 103);
    chk("seq_s0_y_c2", mi_if.locations[0][AXIS_Y], 195);
    chk("seq_s1_pending_c2", mi_if.locations[1][AXIS_X], 10);
    tick();
    chk("seq_s1_x_c3", mi_if.locations[1][AXIS_X], 11);
    for (int c = 4; c <= 9; c++) begin
      tick();
      chk($sformatf("seq_busy_c%0d", c), mi_if.busy, 1);
      chk($sformatf("seq_nodone_c%0d", c), mi_if.done, 0);
    end
    tick();
    chk("seq_done_c10", mi_if.done, 1);
    tick();
    chk("seq_done_gone", mi_if.done, 0);
    chk("seq_idle_busy", mi_if.busy, 0);

    // Snapshot isolates the running frame from new_velos changes.
    l = '0; v = '0;
    l[5] = mkvec(100, 100); v[5] = mkvec(1, 1);
    mi_if.new_velos = v;
    load_state(l, v);
    mi_if.frame_tick = 1'b1;
    tick();
    mi_if.frame_tick = 1'b0;
    tick();
    mi_if.new_velos[5] = mkvec(10, 10);
    cyc = 2;
    while (!mi_if.done && cyc < 50) begin tick(); cyc++; end
    chk("snap_latency", cyc, 10);
    tick();
    chk("snap_s5_x", mi_if.locations[5][AXIS_X], 101);
    chk("snap_s5_vel", mi_if.velos[5][AXIS_Y], 1);
    run_frame(cyc);
    chk("snap_next_x", mi_if.locations[5][AXIS_X], 111);
    chk("snap_next_vel", mi_if.velos[5][AXIS_X], 10);

    // A second frame_tick while busy sets overrun and does not start another frame.
    l = '0; v = '0;
    l[0] = mkvec(100, 100); v[0] = mkvec(1, 1);
    mi_if.new_velos = v;
    load_state(l, v);
    mi_if.frame_tick = 1'b1;
    tick();
    mi_if.frame_tick = 1'b0;
    tick();
    tick();
    mi_if.frame_tick = 1'b1;
    tick();
    mi_if.frame_tick = 1'b0;
    chk("ovr_set", mi_if.overrun, 1);
    dcnt = 0;
    for (int c = 0; c < 25; c++) begin
      if (mi_if.done) dcnt++;
      tick();
    end
    chk("ovr_one_done", dcnt, 1);
    chk("ovr_one_step", mi_if.locations[0][AXIS_X], 101);
    chk("ovr_sticky", mi_if.overrun, 1);
    load_state(l, v);
    chk("ovr_load_clears", mi_if.overrun, 0);

    // Load mid-STEP aborts the frame.
    mi_if.frame_tick = 1'b1;
    tick();
    mi_if.frame_tick = 1'b0;
    tick(); tick(); tick();
    l2 = '0; v2 = '0;
    l2[0] = mkvec(7, 9);   v2[0] = mkvec(-2, 2);
    l2[8] = mkvec(50, 60); v2[8] = mkvec(4, -4);
    load_state(l2, v2);
    chk_arr("abort_locs", mi_if.locations, l2);
    chk_arr("abort_velos", mi_if.velos, v2);
    chk("abort_busy", mi_if.busy, 0);
    chk("abort_done", mi_if.done, 0);
    dcnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (mi_if.done || mi_if.busy) dcnt++;
      tick();
    end
    chk("abort_quiet", dcnt, 0);

    // load and frame_tick together: load wins, no frame, no overrun.
    mi_if.frame_tick = 1'b1;
    load_state(l, v);
    mi_if.frame_tick = 1'b0;
    chk("ldft_busy", mi_if.busy, 0);
    chk("ldft_overrun", mi_if.overrun, 0);
    chk_arr("ldft_locs", mi_if.locations, l);

    // Asynchronous reset mid-STEP.
    mi_if.new_velos = '0;
    mi_if.new_velos[0] = mkvec(3, 4);
    mi_if.frame_tick = 1'b1;
    tick();
    mi_if.frame_tick = 1'b0;
    tick();
    mi_if.frame_tick = 1'b1;
    tick();
    mi_if.frame_tick = 1'b0;
    tick();
    chk("rst_pre_overrun", mi_if.overrun, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_arr("rst_locs", mi_if.locations, '0);
    chk_arr("rst_velos", mi_if.velos, '0);
    chk("rst_busy", mi_if.busy, 0);
    chk("rst_done", mi_if.done, 0);
    chk("rst_overrun", mi_if.overrun, 0);
    tick();
    rst = 1'b0;
    tick();
    run_frame(cyc);
    chk("rst_restart_latency", cyc, 10);
    chk("rst_restart_x", mi_if.locations[0][AXIS_X], 3);
    chk("rst_restart_y", mi_if.locations[0][AXIS_Y], 4);
    chk("rst_restart_vel", mi_if.velos[0][AXIS_Y], 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
